apb_bridge: RTL and testbench
=============================

Name: apb_bridge

Overview:
- Parametrised APB4 requester: converts a single valid/ready register-access request into an APB4 transfer on one of NSLV slave ports.
- Uses the codebase's ApbReq/ApbResp structs per port.
- Sits between the core's uncached/MMIO path (or a debug module) and the peripheral APB segment.
- Adds address decode, a decode-error response, per-transfer wait-state handling and an optional watchdog timeout.

Parameters:
- NSLV, 4, number of APB slave ports (1..16).
- SLV_BASE, {NSLV{`PADDR_SIZE'h0}}, per-slave base address array.
- SLV_MASK, {NSLV{`PADDR_SIZE'h0}}, per-slave mask. Slave i hits when (addr & SLV_MASK[i]) == SLV_BASE[i].
- TIMEOUT, 256, ACCESS-phase cycle limit before abort (≥1). Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted
- req_addr  in  `PADDR_SIZE  byte address
- req_write  in  1  1=write
- req_wdata  in  `XLEN  write data
- req_strb  in  `XLEN/8  write byte strobes
- req_prot  in  3  pprot value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  `XLEN  read data
- rsp_err  out  1  slave error, decode error or timeout
- apb_req  out  NSLV×ApbReq  per-slave request struct
- apb_resp  in  NSLV×ApbResp  per-slave response struct

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - req_ready=0 while rst is low, then 1 in IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All apb_req fields 0 (psel/penable drop immediately, including mid-transfer). No response is produced for an aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP. The bridge handles one transfer at a time.
- IDLE:
  - req_ready=1; in every other state req_ready=0.
  - On req_valid&req_ready, register addr, write, wdata, strb and prot.
  - Decode in parallel. The lowest-index matching slave wins; register its index.
  - Hit → SETUP. No hit → RESP with rsp_err=1, rsp_rdata=0, and no APB activity.
- SETUP (exactly 1 cycle): selected slave psel=1, penable=0 → ACCESS.
- ACCESS:
  - psel=1, penable=1; hold until the selected pready=1.
  - On pready: capture prdata on reads (rsp_rdata=0 on writes) and rsp_err=pslverr → RESP.
- RESP:
  - rsp_valid=1 with stable rdata/err until rsp_ready; then → IDLE.
  - rsp_valid and req_ready are never both 1 in the same cycle.
- APB request fields:
  - paddr, pwrite, pwdata and pprot are broadcast to all ports from the registered request. They are held constant from SETUP through ACCESS and are don't-care otherwise (driven 0 in IDLE/RESP).
  - pstrb = registered strb on writes and 0 on reads (APB4 rule).
  - Only the selected port's psel is ever 1.
- Latency:
  - Acceptance edge → SETUP next cycle.
  - Minimum 3 cycles from acceptance to rsp_valid (zero-wait slave).
  - Each wait state adds 1 cycle.
- pready and pslverr from unselected slaves are ignored.

Optional Feature:
- Macro: APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entry to ACCESS and increments every ACCESS cycle without pready.
  - When the count reaches TIMEOUT with pready still 0, the bridge deasserts psel/penable the next cycle and enters RESP with rsp_err=1, rsp_rdata=0.
  - If pready arrives in the same cycle the count reaches TIMEOUT, pready wins and the transfer completes normally.
- Undefined: no counter; ACCESS waits indefinitely, and the TIMEOUT parameter is unused.

Test Plan:
- Zero-wait read: NSLV=4, slave1 base 0x1000_0000 mask 0xF000_0000; read 0x1000_0004, slave returns prdata=0xDEADBEEF with pready in ACCESS → psel[1] for 2 cycles, rsp_valid 3 cycles after acceptance, rdata=0xDEADBEEF, err=0.
- Write with 2 wait states: write 0x1000_0008, wdata=0x12345678, strb=0xF → pstrb=0xF and pwdata stable for 4 APB cycles; rsp_valid 5 cycles after acceptance, rdata=0, err=0.
- Decode miss: read 0xF000_0000 with no matching slave → no psel asserted, rsp_valid 1 cycle after acceptance with err=1, rdata=0.
- Slave error plus backpressure: pslverr=1 with pready, rsp_ready held 0 for 3 cycles → rsp_valid/err held stable; req_ready=0 until the cycle after the rsp handshake.
- Timeout (APB_BRIDGE_TIMEOUT_EN, TIMEOUT=8): slave never asserts pready → psel dropped after 8 ACCESS cycles, err=1. Repeat with pready on exactly the 8th cycle → normal completion, err=0.
- Reset mid-ACCESS: assert rst=0 during a wait state → psel/penable=0 asynchronously and no rsp_valid; after release req_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/apb_bridge.sv
// apb_bridge: single valid/ready register request to APB4 transfer on one of NSLV slave ports.
// Optional ACCESS-phase watchdog enabled by defining APB_BRIDGE_TIMEOUT_EN.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package apb_bridge_pkg;
   typedef struct packed {
      logic                    psel;
      logic                    penable;
      logic [`PADDR_SIZE-1:0]  paddr;
      logic                    pwrite;
      logic [`XLEN-1:0]        pwdata;
      logic [`XLEN/8-1:0]      pstrb;
      logic [2:0]              pprot;
   } ApbReq;

   typedef struct packed {
      logic [`XLEN-1:0] prdata;
      logic             pready;
      logic             pslverr;
   } ApbResp;
endpackage

module apb_bridge
   import apb_bridge_pkg::*;
#(
   parameter int unsigned                           NSLV     = 4,
   parameter logic [NSLV-1:0][`PADDR_SIZE-1:0]      SLV_BASE = {NSLV{`PADDR_SIZE'h0}},
   parameter logic [NSLV-1:0][`PADDR_SIZE-1:0]      SLV_MASK = {NSLV{`PADDR_SIZE'h0}},
   parameter int unsigned                           TIMEOUT  = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [`PADDR_SIZE-1:0]  req_addr,
   input  logic                    req_write,
   input  logic [`XLEN-1:0]        req_wdata,
   input  logic [`XLEN/8-1:0]      req_strb,
   input  logic [2:0]              req_prot,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [`XLEN-1:0]        rsp_rdata,
   output logic                    rsp_err,
   output ApbReq [NSLV-1:0]        apb_req,
   input  ApbResp [NSLV-1:0]       apb_resp
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;

   state_t                  r_state;
   logic [IW-1:0]           r_sel;
   logic                    r_req_ready;
   logic                    r_rsp_valid;
   logic                    r_rsp_err;
   logic [`XLEN-1:0]        r_rsp_rdata;
   logic [NSLV-1:0]         r_psel;
   logic                    r_penable;
   logic [`PADDR_SIZE-1:0]  r_paddr;
   logic                    r_pwrite;
   logic [`XLEN-1:0]        r_pwdata;
   logic [`XLEN/8-1:0]      r_pstrb;
   logic [2:0]              r_pprot;

   logic                    w_hit;
   logic [IW-1:0]           w_hit_idx;
   ApbResp                  w_sel_resp;
   logic                    w_tmo;
   logic                    w_done;

   // Ascending scan with a found flag gives the lowest matching index priority.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (!w_hit && ((req_addr & SLV_MASK[i]) == SLV_BASE[i])) begin
            w_hit     = 1'b1;
            w_hit_idx = IW'(i);
         end
      end
   end

   assign w_sel_resp = apb_resp[r_sel];

`ifdef APB_BRIDGE_TIMEOUT_EN
   localparam int unsigned         CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]       TO_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_cnt;

   // Abort on the edge where the wait count would reach TIMEOUT; pready in that cycle still wins.
   assign w_tmo = (r_state == ACCESS) && !w_sel_resp.pready && (r_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (r_state == SETUP) begin
         r_cnt <= '0;
      end else if (r_state == ACCESS && !w_sel_resp.pready && !w_tmo) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT;
   assign w_tmo            = 1'b0;
`endif

   assign w_done = (r_state == ACCESS) && (w_sel_resp.pready || w_tmo);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_sel       <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_psel      <= '0;
         r_penable   <= 1'b0;
         r_paddr     <= '0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_pstrb     <= '0;
         r_pprot     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_req_ready <= 1'b1;
               if (req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  if (w_hit) begin
                     r_state  <= SETUP;
                     r_sel    <= w_hit_idx;
                     r_psel   <= NSLV'(1) << w_hit_idx;
                     r_paddr  <= req_addr;
                     r_pwrite <= req_write;
                     r_pwdata <= req_wdata;
                     r_pstrb  <= req_write ? req_strb : '0;
                     r_pprot  <= req_prot;
                  end else begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               if (w_done) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_sel_resp.pready ? w_sel_resp.pslverr : 1'b1;
                  r_rsp_rdata <= (w_sel_resp.pready && !r_pwrite) ? w_sel_resp.prdata : '0;
                  r_psel      <= '0;
                  r_penable   <= 1'b0;
                  r_paddr     <= '0;
                  r_pwrite    <= 1'b0;
                  r_pwdata    <= '0;
                  r_pstrb     <= '0;
                  r_pprot     <= '0;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NSLV; i++) begin
         apb_req[i].psel    = r_psel[i];
         apb_req[i].penable = r_penable & r_psel[i];
         apb_req[i].paddr   = r_paddr;
         apb_req[i].pwrite  = r_pwrite;
         apb_req[i].pwdata  = r_pwdata;
         apb_req[i].pstrb   = r_pstrb;
         apb_req[i].pprot   = r_pprot;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_bridge.sv
// Table-driven bench for apb_bridge: 4 slaves, per-vector slave wait/error model, plus reset sequences.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_apb_bridge;
   import apb_bridge_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   req_valid;
   logic                   req_ready;
   logic [`PADDR_SIZE-1:0] req_addr;
   logic                   req_write;
   logic [`XLEN-1:0]       req_wdata;
   logic [`XLEN/8-1:0]     req_strb;
   logic [2:0]             req_prot;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [`XLEN-1:0]       rsp_rdata;
   logic                   rsp_err;
   ApbReq  [3:0]           apb_req;
   ApbResp [3:0]           apb_resp;

   int errors = 0;
   int checks = 0;

   apb_bridge #(
      .NSLV     (4),
      .SLV_BASE ({32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
      .SLV_MASK ({32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
      .TIMEOUT  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_write (req_write),
      .req_wdata (req_wdata),
      .req_strb  (req_strb),
      .req_prot  (req_prot),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .apb_req   (apb_req),
      .apb_resp  (apb_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      int          exp_slv;
      int          exp_lat;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          bp;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Unselected slaves constantly assert pready/pslverr to prove they are ignored.
   task automatic set_noise();
      for (int i = 0; i < 4; i++)
         apb_resp[i] = '{prdata: 32'hBADB_AD00, pready: 1'b1, pslverr: 1'b1};
   endtask

   task automatic run_vec(input vec_t v);
      int   cyc, acc, psel_cnt, stray, bad;
      logic seen;
      logic [31:0] held_rdata;
      logic        held_err;
      @(negedge clk);
      chk({v.name, ".req_ready_idle"}, 32'(req_ready), 32'd1);
      set_noise();
      if (v.exp_slv >= 0) apb_resp[v.exp_slv] = '{prdata: 32'h0, pready: 1'b0, pslverr: 1'b0};
      req_valid = 1'b1; req_addr = v.addr; req_write = v.write;
      req_wdata = v.wdata; req_strb = v.strb; req_prot = v.prot;
      rsp_ready = 1'b1;
      cyc = 0; acc = 0; psel_cnt = 0; stray = 0; bad = 0; seen = 1'b0;
      while (cyc < 40 && !seen) begin
         @(negedge clk);
         cyc++;
         req_valid = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (apb_req[i].psel) begin
               if (i == v.exp_slv) psel_cnt++;
               else stray++;
               if (apb_req[i].paddr !== v.addr || apb_req[i].pwrite !== v.write ||
                   apb_req[i].pprot !== v.prot ||
                   apb_req[i].pstrb !== (v.write ? v.strb : 4'h0) ||
                   (v.write && apb_req[i].pwdata !== v.wdata))
                  bad++;
            end
         end
         if (rsp_valid) begin
            seen = 1'b1;
            chk({v.name, ".req_ready_in_resp"}, 32'(req_ready), 32'd0);
         end else if (v.exp_slv >= 0) begin
            apb_resp[v.exp_slv] = '{prdata: 32'h0, pready: 1'b0, pslverr: 1'b0};
            if (apb_req[v.exp_slv].psel && apb_req[v.exp_slv].penable) begin
               acc++;
               if (acc > v.waits)
                  apb_resp[v.exp_slv] = '{prdata: v.prdata, pready: 1'b1, pslverr: v.slverr};
            end
         end
      end
      chk({v.name, ".rsp_seen"}, 32'(seen), 32'd1);
      chk({v.name, ".latency"}, 32'(cyc), 32'(v.exp_lat));
      chk({v.name, ".rdata"}, rsp_rdata, v.exp_rdata);
      chk({v.name, ".err"}, 32'(rsp_err), 32'(v.exp_err));
      chk({v.name, ".psel_cycles"}, 32'(psel_cnt), (v.exp_slv < 0) ? 32'd0 : 32'(v.exp_lat - 1));
      chk({v.name, ".stray_psel"}, 32'(stray), 32'd0);
      chk({v.name, ".apb_fields"}, 32'(bad), 32'd0);
      held_rdata = rsp_rdata;
      held_err   = rsp_err;
      if (v.bp > 0) begin
         rsp_ready = 1'b0;
         for (int k = 1; k <= v.bp; k++) begin
            @(negedge clk);
            chk($sformatf("%s.bp%0d_valid", v.name, k), 32'(rsp_valid), 32'd1);
            chk($sformatf("%s.bp%0d_rdata", v.name, k), rsp_rdata, held_rdata);
            chk($sformatf("%s.bp%0d_err", v.name, k), 32'(rsp_err), 32'(held_err));
            chk($sformatf("%s.bp%0d_req_ready", v.name, k), 32'(req_ready), 32'd0);
            if (k == v.bp) rsp_ready = 1'b1;
         end
      end
      @(negedge clk);
      chk({v.name, ".rsp_valid_after_hs"}, 32'(rsp_valid), 32'd0);
      chk({v.name, ".req_ready_after_hs"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      //         name          addr          wr    wdata         strb  prot    waits prdata        serr  slv lat rdata         err bp
      vecs.push_back('{"rd0w",   32'h1000_0004, 1'b0, 32'h0,        4'h0, 3'b000, 0, 32'hDEAD_BEEF, 1'b0, 1,  3, 32'hDEAD_BEEF, 1'b0, 0});
      vecs.push_back('{"wr2w",   32'h1000_0008, 1'b1, 32'h1234_5678, 4'hF, 3'b001, 2, 32'h55AA_55AA, 1'b0, 1,  5, 32'h0,         1'b0, 0});
      vecs.push_back('{"miss",   32'hF000_0000, 1'b0, 32'h0,        4'h0, 3'b000, 0, 32'h0,         1'b0, -1, 1, 32'h0,         1'b1, 0});
      vecs.push_back('{"prio",   32'h2000_0010, 1'b0, 32'h0,        4'h0, 3'b100, 1, 32'h0BAD_C0DE, 1'b0, 2,  4, 32'h0BAD_C0DE, 1'b0, 0});
      vecs.push_back('{"wrstrb", 32'h0000_0100, 1'b1, 32'hA5A5_0F0F, 4'h3, 3'b010, 0, 32'h0,         1'b0, 0,  3, 32'h0,         1'b0, 0});
      vecs.push_back('{"errbp",  32'h1000_0040, 1'b0, 32'h0,        4'h0, 3'b000, 0, 32'h1111_2222, 1'b1, 1,  3, 32'h1111_2222, 1'b1, 3});
      vecs.push_back('{"wrerr",  32'h0000_0200, 1'b1, 32'h0F0F_F0F0, 4'hC, 3'b011, 1, 32'h0,         1'b1, 0,  4, 32'h0,         1'b1, 0});
`ifdef APB_BRIDGE_TIMEOUT_EN
      vecs.push_back('{"tmoabt", 32'h1000_0020, 1'b0, 32'h0,        4'h0, 3'b000, 100, 32'h0,       1'b0, 1, 10, 32'h0,         1'b1, 0});
      vecs.push_back('{"tmoedg", 32'h1000_0024, 1'b0, 32'h0,        4'h0, 3'b000, 7, 32'hCAFE_F00D, 1'b0, 1, 10, 32'hCAFE_F00D, 1'b0, 0});
`endif

      rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
      req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b1;
      set_noise();
      #12;
      chk("rst.req_ready", 32'(req_ready), 32'd0);
      chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst.rsp_rdata", rsp_rdata, 32'd0);
      chk("rst.rsp_err", 32'(rsp_err), 32'd0);
      chk("rst.apb_req_zero", 32'(apb_req == '0), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst.req_ready", 32'(req_ready), 32'd1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset asserted during an ACCESS wait state.
      @(negedge clk);
      set_noise();
      apb_resp[1] = '{prdata: 32'h0, pready: 1'b0, pslverr: 1'b0};
      req_valid = 1'b1; req_addr = 32'h1000_0010; req_write = 1'b0; req_strb = '0; req_prot = '0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstmid.psel_before", 32'(apb_req[1].psel), 32'd1);
      chk("rstmid.penable_before", 32'(apb_req[1].penable), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rstmid.psel", 32'(apb_req[1].psel), 32'd0);
      chk("rstmid.penable", 32'(apb_req[1].penable), 32'd0);
      chk("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid.req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid.req_ready_after", 32'(req_ready), 32'd1);
      chk("rstmid.rsp_valid_after", 32'(rsp_valid), 32'd0);
      chk("rstmid.apb_idle", 32'(apb_req == '0), 32'd1);
      run_vec(vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
